mc_control_fsm: RTL and testbench

Multi-cycle control unit that sequences each 16-bit instruction through fetch, decode, execute, memory and write-back, and drives the datapath control word, including the 3-bit ALU operation select and operand muxes. It sits between the instruction register and the shared datapath (ALU, register file, unified memory). It is the producer of every ALU operation code and the consumer of the ALU zero flag.

---
 rtl/mc_control_fsm_pkg.sv | 70 +++++++
 rtl/mc_control_fsm_decode.sv | 81 ++++++++
 rtl/mc_control_fsm.sv | 114 +++++++++++
 tb/tb_mc_control_fsm.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_control_fsm_pkg.sv
// Shared types and encodings for the multi-cycle control unit.
// The TRAP state only exists when ILLEGAL_TRAP_EN is defined.
package mc_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_SH,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_R_WB,
        S_BRANCH,
        S_JUMP,
        S_HALT
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_SHIFT = 4'b0010;
    localparam logic [3:0] OP_NAND  = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_LW    = 4'b0110;
    localparam logic [3:0] OP_SW    = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_JMP   = 4'b1001;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_SHIFT = 3'b010;
    localparam logic [2:0] ALU_NAND  = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_ONE   = 2'b01;
    localparam logic [1:0] SRC_B_SEXT4 = 2'b10;
    localparam logic [1:0] SRC_B_ZEXT8 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [1:0] PC_SRC_TRAP   = 2'b11;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_word_t;

    // Register-register ALU ops, whose opcode[2:0] is the ALU select itself.
    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/mc_control_fsm_decode.sv
// State-to-control-word mapping for mc_control_fsm (purely combinational).
// Honors ILLEGAL_TRAP_EN for the TRAP state's PC load.
module mc_ctrl_decode
    import mc_control_fsm_pkg::*;
(
    input  state_t     i_state,
    input  logic [2:0] i_alu_func,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_word_t o_cw
);

    always_comb begin
        o_cw = '0;
        unique case (i_state)
            S_FETCH: begin
                o_cw.mem_read  = 1'b1;
                o_cw.alu_src_b = SRC_B_ONE;
                o_cw.alu_op    = ALU_ADD;
                o_cw.pc_source = PC_SRC_ALU;
                o_cw.ir_write  = i_mem_ready;
                o_cw.pc_en     = i_mem_ready;
            end
            S_DECODE: begin
                // Branch target precompute into ALUOut.
                o_cw.alu_op    = ALU_ADD;
                o_cw.alu_src_b = SRC_B_SEXT4;
            end
            S_EXEC_R: begin
                o_cw.alu_op    = i_alu_func;
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRC_B_REG;
            end
            S_EXEC_SH: begin
                o_cw.alu_op    = ALU_SHIFT;
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRC_B_ZEXT8;
            end
            S_R_WB: begin
                o_cw.reg_write = 1'b1;
                o_cw.reg_dst   = 1'b1;
            end
            S_MEM_ADDR: begin
                o_cw.alu_op    = ALU_ADD;
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRC_B_SEXT4;
            end
            S_MEM_RD: begin
                o_cw.i_or_d   = 1'b1;
                o_cw.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                o_cw.reg_write  = 1'b1;
                o_cw.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                o_cw.i_or_d    = 1'b1;
                o_cw.mem_write = 1'b1;
            end
            S_BRANCH: begin
                o_cw.alu_op    = ALU_SUB;
                o_cw.alu_src_a = 1'b1;
                o_cw.alu_src_b = SRC_B_REG;
                o_cw.pc_source = PC_SRC_ALUOUT;
                o_cw.pc_en     = i_zero;
            end
            S_JUMP: begin
                o_cw.pc_en     = 1'b1;
                o_cw.pc_source = PC_SRC_JUMP;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                o_cw.pc_en     = 1'b1;
                o_cw.pc_source = PC_SRC_TRAP;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle instruction sequencer: state register, next-state logic, sticky flags.
// Define ILLEGAL_TRAP_EN to trap illegal opcodes to TRAP_VECTOR instead of NOP-ing them.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter logic [15:0] TRAP_VECTOR = 16'h0010
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       pc_en,
    output logic [1:0] pc_source,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       halted,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_halted;
    ctrl_word_t w_dec_cw;
    ctrl_word_t w_cw;

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                if (is_rtype(opcode))                        w_next_state = S_EXEC_R;
                else if (opcode == OP_SHIFT)                 w_next_state = S_EXEC_SH;
                else if (opcode == OP_LW || opcode == OP_SW) w_next_state = S_MEM_ADDR;
                else if (opcode == OP_BEQ)                   w_next_state = S_BRANCH;
                else if (opcode == OP_JMP)                   w_next_state = S_JUMP;
                else if (opcode == OP_HALT)                  w_next_state = S_HALT;
`ifdef ILLEGAL_TRAP_EN
                else                                         w_next_state = S_TRAP;
`else
                else                                         w_next_state = S_FETCH;
`endif
            end
            S_EXEC_R:   w_next_state = S_R_WB;
            S_EXEC_SH:  w_next_state = S_R_WB;
            S_R_WB:     w_next_state = S_FETCH;
            S_MEM_ADDR: w_next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) w_next_state = S_MEM_WB;
            S_MEM_WB:   w_next_state = S_FETCH;
            S_MEM_WR:   if (mem_ready) w_next_state = S_FETCH;
            S_BRANCH:   w_next_state = S_FETCH;
            S_JUMP:     w_next_state = S_FETCH;
            S_HALT:     w_next_state = S_HALT;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_next_state == S_HALT) r_halted <= 1'b1;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic r_illegal;

    always_ff @(posedge clk) begin
        if (rst)                            r_illegal <= 1'b0;
        else if (w_next_state == S_TRAP)    r_illegal <= 1'b1;
    end

    assign illegal = r_illegal & ~rst;
`else
    assign illegal = 1'b0;
`endif

    mc_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_alu_func  (opcode[2:0]),
        .i_zero      (zero),
        .i_mem_ready (mem_ready),
        .o_cw        (w_dec_cw)
    );

    // Reset blanks every output in the cycle it is asserted, even mid-transfer.
    assign w_cw = rst ? '0 : w_dec_cw;

    assign alu_op     = w_cw.alu_op;
    assign alu_src_a  = w_cw.alu_src_a;
    assign alu_src_b  = w_cw.alu_src_b;
    assign pc_en      = w_cw.pc_en;
    assign pc_source  = w_cw.pc_source;
    assign i_or_d     = w_cw.i_or_d;
    assign mem_read   = w_cw.mem_read;
    assign mem_write  = w_cw.mem_write;
    assign ir_write   = w_cw.ir_write;
    assign reg_write  = w_cw.reg_write;
    assign reg_dst    = w_cw.reg_dst;
    assign mem_to_reg = w_cw.mem_to_reg;
    assign halted     = r_halted & ~rst;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control words are queued
// by the stimulus and popped/compared by an independent monitor on the falling edge.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [17:0] v;
    } exp_t;

    exp_t q[$];
    logic exp_ill = 1'b0;

    always #5 clk = ~clk;

    mc_control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .halted     (halted),
        .illegal    (illegal)
    );

    // {alu_op, src_a, src_b, pc_en, pc_source, {i_or_d, mem_read, mem_write, ir_write},
    //  {reg_write, reg_dst, mem_to_reg}, halted}
    localparam logic [16:0] E_ZERO     = 17'd0;
    localparam logic [16:0] E_FETCH    = {3'b000, 1'b0, 2'b01, 1'b1, 2'b00, 4'b0101, 3'b000, 1'b0};
    localparam logic [16:0] E_FETCH_W  = {3'b000, 1'b0, 2'b01, 1'b0, 2'b00, 4'b0100, 3'b000, 1'b0};
    localparam logic [16:0] E_DECODE   = {3'b000, 1'b0, 2'b10, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_EX_ADD   = {3'b000, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_EX_SUB   = {3'b001, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_EX_NAND  = {3'b011, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_EX_OR    = {3'b100, 1'b1, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_EX_SH    = {3'b010, 1'b1, 2'b11, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_R_WB     = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b110, 1'b0};
    localparam logic [16:0] E_MEM_ADDR = {3'b000, 1'b1, 2'b10, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_MEM_RD   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1100, 3'b000, 1'b0};
    localparam logic [16:0] E_MEM_WB   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b101, 1'b0};
    localparam logic [16:0] E_MEM_WR   = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 4'b1010, 3'b000, 1'b0};
    localparam logic [16:0] E_BR_T     = {3'b001, 1'b1, 2'b00, 1'b1, 2'b01, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_BR_N     = {3'b001, 1'b1, 2'b00, 1'b0, 2'b01, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_JUMP     = {3'b000, 1'b0, 2'b00, 1'b1, 2'b10, 4'b0000, 3'b000, 1'b0};
    localparam logic [16:0] E_HALT     = {3'b000, 1'b0, 2'b00, 1'b0, 2'b00, 4'b0000, 3'b000, 1'b1};
    localparam logic [16:0] E_TRAP     = {3'b000, 1'b0, 2'b00, 1'b1, 2'b11, 4'b0000, 3'b000, 1'b0};

    // One clock cycle: drive inputs just after the edge and queue the expected outputs.
    task automatic cyc(input string nm, input logic [3:0] op, input logic z,
                       input logic mr, input logic r, input logic [16:0] e);
        exp_t item;
        @(posedge clk);
        #1;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        rst       = r;
        item.name = nm;
        item.v    = {e, r ? 1'b0 : exp_ill};
        q.push_back(item);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {alu_op, alu_src_a, alu_src_b, pc_en, pc_source,
                       i_or_d, mem_read, mem_write, ir_write,
                       reg_write, reg_dst, mem_to_reg, halted, illegal};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got %b expected %b", e.name, act, e.v);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1; opcode = 4'b0000; zero = 1'b0; mem_ready = 1'b0;
        cyc("reset0", 4'b0000, 1'b0, 1'b1, 1'b1, E_ZERO);
        cyc("reset1", 4'b0000, 1'b0, 1'b1, 1'b1, E_ZERO);

        // ADD with one fetch wait, then 4 zero-wait cycles
        cyc("add_fetch_wait", 4'b0000, 1'b0, 1'b0, 1'b0, E_FETCH_W);
        cyc("add_fetch",      4'b0000, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("add_decode",     4'b0000, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("add_exec",       4'b0000, 1'b0, 1'b1, 1'b0, E_EX_ADD);
        cyc("add_wb",         4'b0000, 1'b0, 1'b1, 1'b0, E_R_WB);

        cyc("sub_fetch",  4'b0001, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("sub_decode", 4'b0001, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("sub_exec",   4'b0001, 1'b0, 1'b1, 1'b0, E_EX_SUB);
        cyc("sub_wb",     4'b0001, 1'b0, 1'b1, 1'b0, E_R_WB);

        cyc("sh_fetch",  4'b0010, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("sh_decode", 4'b0010, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("sh_exec",   4'b0010, 1'b0, 1'b1, 1'b0, E_EX_SH);
        cyc("sh_wb",     4'b0010, 1'b0, 1'b1, 1'b0, E_R_WB);

        cyc("nand_fetch",  4'b0011, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("nand_decode", 4'b0011, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("nand_exec",   4'b0011, 1'b0, 1'b1, 1'b0, E_EX_NAND);
        cyc("nand_wb",     4'b0011, 1'b0, 1'b1, 1'b0, E_R_WB);

        cyc("or_fetch",  4'b0100, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("or_decode", 4'b0100, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("or_exec",   4'b0100, 1'b0, 1'b1, 1'b0, E_EX_OR);
        cyc("or_wb",     4'b0100, 1'b0, 1'b1, 1'b0, E_R_WB);

        // LW with three wait cycles in MEM_RD: 8 cycles total
        cyc("lw_fetch",  4'b0110, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("lw_decode", 4'b0110, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("lw_addr",   4'b0110, 1'b0, 1'b1, 1'b0, E_MEM_ADDR);
        for (int i = 0; i < 3; i++)
            cyc("lw_rd_wait", 4'b0110, 1'b0, 1'b0, 1'b0, E_MEM_RD);
        cyc("lw_rd",     4'b0110, 1'b0, 1'b1, 1'b0, E_MEM_RD);
        cyc("lw_wb",     4'b0110, 1'b0, 1'b1, 1'b0, E_MEM_WB);

        cyc("sw_fetch",  4'b0111, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("sw_decode", 4'b0111, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("sw_addr",   4'b0111, 1'b0, 1'b1, 1'b0, E_MEM_ADDR);
        cyc("sw_wr",     4'b0111, 1'b0, 1'b1, 1'b0, E_MEM_WR);

        cyc("beq_t_fetch",  4'b1000, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("beq_t_decode", 4'b1000, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("beq_taken",    4'b1000, 1'b1, 1'b1, 1'b0, E_BR_T);
        cyc("beq_n_fetch",  4'b1000, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("beq_n_decode", 4'b1000, 1'b1, 1'b1, 1'b0, E_DECODE);
        cyc("beq_not",      4'b1000, 1'b0, 1'b1, 1'b0, E_BR_N);

        cyc("jmp_fetch",  4'b1001, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("jmp_decode", 4'b1001, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("jmp",        4'b1001, 1'b0, 1'b1, 1'b0, E_JUMP);

        cyc("ill_fetch",  4'b1010, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("ill_decode", 4'b1010, 1'b0, 1'b1, 1'b0, E_DECODE);
`ifdef ILLEGAL_TRAP_EN
        exp_ill = 1'b1;
        cyc("ill_trap",   4'b1010, 1'b0, 1'b1, 1'b0, E_TRAP);
`endif
        cyc("ill_after",  4'b0000, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("ill_decode2",4'b0000, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("ill_exec2",  4'b0000, 1'b0, 1'b1, 1'b0, E_EX_ADD);
        cyc("ill_wb2",    4'b0000, 1'b0, 1'b1, 1'b0, E_R_WB);

        // Reset mid-MEM_WR with mem_ready high: no write may escape
        cyc("swr_fetch",  4'b0111, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("swr_decode", 4'b0111, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("swr_addr",   4'b0111, 1'b0, 1'b1, 1'b0, E_MEM_ADDR);
        cyc("swr_wait",   4'b0111, 1'b0, 1'b0, 1'b0, E_MEM_WR);
        exp_ill = 1'b0;
        cyc("swr_reset",  4'b0111, 1'b0, 1'b1, 1'b1, E_ZERO);
        cyc("swr_refetch",4'b1111, 1'b0, 1'b1, 1'b0, E_FETCH);

        cyc("halt_decode",4'b1111, 1'b0, 1'b1, 1'b0, E_DECODE);
        cyc("halt_0",     4'b1111, 1'b0, 1'b1, 1'b0, E_HALT);
        cyc("halt_1",     4'b0000, 1'b1, 1'b1, 1'b0, E_HALT);
        cyc("halt_reset", 4'b0000, 1'b0, 1'b1, 1'b1, E_ZERO);
        cyc("halt_refetch_wait", 4'b0000, 1'b0, 1'b0, 1'b0, E_FETCH_W);
        cyc("halt_refetch",      4'b0000, 1'b0, 1'b1, 1'b0, E_FETCH);
        cyc("halt_after_decode", 4'b0000, 1'b0, 1'b1, 1'b0, E_DECODE);

        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
